// File: rtl/timer_share_pkg.sv
// Shared definitions for the interval-timer sharing controller: timer register map,
// control-register bit positions and the controller state encoding.
package timer_share_pkg;

    localparam logic [2:0] TMR_STATUS  = 3'd0;
    localparam logic [2:0] TMR_CONTROL = 3'd1;
    localparam logic [2:0] TMR_PERIODL = 3'd2;
    localparam logic [2:0] TMR_PERIODH = 3'd3;
    localparam logic [2:0] TMR_SNAPL   = 3'd4;
    localparam logic [2:0] TMR_SNAPH   = 3'd5;

    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    // One-shot start with interrupt enabled; CONT and STOP stay clear.
    localparam logic [15:0] CTL_ONESHOT = (16'h0001 << CTL_START) | (16'h0001 << CTL_ITO);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_PL  = 3'd1,
        ST_WR_PH  = 3'd2,
        ST_WR_CTL = 3'd3,
        ST_WAIT   = 3'd4,
        ST_CLR    = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

endpackage

// File: rtl/timer_share_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, wrapping.
// The pointer register itself lives in the parent.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   id
);

    int   dist_s;
    int   best_s;
    int   pick_s;
    logic take_s;
    logic found_s;

    // Smallest wrap distance from ptr+1 among active requesters wins.
    always_comb begin
        dist_s  = 0;
        best_s  = N_REQ;
        pick_s  = 0;
        take_s  = 1'b0;
        found_s = 1'b0;
        gnt     = '0;
        for (int j = 0; j < N_REQ; j++) begin
            dist_s = (j + 2 * N_REQ - int'(ptr) - 1) % N_REQ;
            take_s = en && req[j] && (dist_s < best_s);
            best_s = take_s ? dist_s : best_s;
            pick_s = take_s ? j : pick_s;
        end
        found_s = (best_s < N_REQ);
        for (int j = 0; j < N_REQ; j++) begin
            gnt[j] = found_s && (pick_s == j);
        end
        id = found_s ? IDW'(pick_s) : '0;
    end

endmodule

// File: rtl/timer_share_ctrl.sv
// Avalon-MM master sharing one interval timer among N_REQ one-shot delay requesters:
// round-robin grant, program period/control, wait for irq, clear status, pulse done.
module timer_share_ctrl
    import timer_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [32*N_REQ-1:0] delay,
    output logic [N_REQ-1:0]    done,
    output logic [IDW-1:0]      grant_id,
    output logic                busy,
    output logic [2:0]          avm_address,
    output logic                avm_chipselect,
    output logic                avm_write_n,
    output logic [15:0]         avm_writedata,
    input  logic                timer_irq
);

    state_e             state_r;
    state_e             state_next_s;
    logic [IDW-1:0]     ptr_r;
    logic [IDW-1:0]     id_r;
    logic [31:0]        delay_r;

    logic               arb_en_s;
    logic [N_REQ-1:0]   arb_gnt_s;
    logic [IDW-1:0]     arb_id_s;
    logic               grant_s;
    logic [31:0]        delay_pick_s;
    logic [IDW-1:0]     id_nx_s;
    logic [31:0]        delay_nx_s;

    logic               cs_nx_s;
    logic               wn_nx_s;
    logic [2:0]         addr_nx_s;
    logic [15:0]        data_nx_s;
    logic               busy_nx_s;
    logic [N_REQ-1:0]   done_nx_s;

    logic               cs_r;
    logic               wn_r;
    logic [2:0]         addr_r;
    logic [15:0]        data_r;
    logic               busy_r;
    logic [N_REQ-1:0]   done_r;
    logic [IDW-1:0]     grant_id_r;

    assign arb_en_s = (state_r == ST_IDLE);

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .req (req),
        .ptr (ptr_r),
        .en  (arb_en_s),
        .gnt (arb_gnt_s),
        .id  (arb_id_s)
    );

    assign grant_s = |arb_gnt_s;

    // Select the winner's delay word using the one-hot grant.
    always_comb begin
        delay_pick_s = 32'd0;
        for (int i = 0; i < N_REQ; i++) begin
            delay_pick_s = delay_pick_s | ({32{arb_gnt_s[i]}} & delay[32*i +: 32]);
        end
    end

    // Outputs are registered, so they are computed from the values valid after this edge.
    assign id_nx_s    = grant_s ? arb_id_s : id_r;
    assign delay_nx_s = grant_s ? delay_pick_s : delay_r;

    // State register plus id/delay/pointer latches taken at grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            ptr_r   <= IDW'(N_REQ - 1);
            id_r    <= '0;
            delay_r <= 32'd0;
        end else begin
            state_r <= state_next_s;
            if (grant_s) begin
                ptr_r   <= arb_id_s;
                id_r    <= arb_id_s;
                delay_r <= delay_pick_s;
            end
        end
    end

    // Next-state logic: one bus write per write state, zero delay skips the timer.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_next_s = (delay_pick_s == 32'd0) ? ST_DONE : ST_WR_PL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WR_PL:  state_next_s = ST_WR_PH;
            ST_WR_PH:  state_next_s = ST_WR_CTL;
            ST_WR_CTL: state_next_s = ST_WAIT;
            ST_WAIT: begin
                if (timer_irq) begin
                    state_next_s = ST_CLR;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_CLR:    state_next_s = ST_DONE;
            ST_DONE:   state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Output decode for the upcoming state.
    always_comb begin
        cs_nx_s   = 1'b0;
        wn_nx_s   = 1'b1;
        addr_nx_s = 3'd0;
        data_nx_s = 16'h0000;
        busy_nx_s = (state_next_s != ST_IDLE);
        case (state_next_s)
            ST_WR_PL: begin
                cs_nx_s   = 1'b1;
                wn_nx_s   = 1'b0;
                addr_nx_s = TMR_PERIODL;
                data_nx_s = delay_nx_s[15:0];
            end
            ST_WR_PH: begin
                cs_nx_s   = 1'b1;
                wn_nx_s   = 1'b0;
                addr_nx_s = TMR_PERIODH;
                data_nx_s = delay_nx_s[31:16];
            end
            ST_WR_CTL: begin
                cs_nx_s   = 1'b1;
                wn_nx_s   = 1'b0;
                addr_nx_s = TMR_CONTROL;
                data_nx_s = CTL_ONESHOT;
            end
            ST_CLR: begin
                cs_nx_s   = 1'b1;
                wn_nx_s   = 1'b0;
                addr_nx_s = TMR_STATUS;
                data_nx_s = 16'h0000;
            end
            default: begin
                cs_nx_s   = 1'b0;
                wn_nx_s   = 1'b1;
            end
        endcase
        for (int i = 0; i < N_REQ; i++) begin
            done_nx_s[i] = (state_next_s == ST_DONE) && (id_nx_s == IDW'(i));
        end
    end

    // Output registers; reset leaves the bus deselected with write_n high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_r       <= 1'b0;
            wn_r       <= 1'b1;
            addr_r     <= 3'd0;
            data_r     <= 16'h0000;
            busy_r     <= 1'b0;
            done_r     <= '0;
            grant_id_r <= '0;
        end else begin
            cs_r       <= cs_nx_s;
            wn_r       <= wn_nx_s;
            addr_r     <= addr_nx_s;
            data_r     <= data_nx_s;
            busy_r     <= busy_nx_s;
            done_r     <= done_nx_s;
            grant_id_r <= id_nx_s;
        end
    end

    assign avm_chipselect = cs_r;
    assign avm_write_n    = wn_r;
    assign avm_address    = addr_r;
    assign avm_writedata  = data_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign grant_id       = grant_id_r;

endmodule

// File: tb/tb_timer_share_ctrl.sv
// Bench for timer_share_ctrl with a behavioural interval timer on the same clock;
// directed scenarios plus a randomized round-robin run against a queue-level model.
module tb_timer_share_ctrl;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [32*N-1:0] delay;
    logic [N-1:0]   done;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic [2:0]     avm_address;
    logic           avm_chipselect;
    logic           avm_write_n;
    logic [15:0]    avm_writedata;
    logic           timer_irq;

    int checks   = 0;
    int failures = 0;

    logic [19:0] bus_q[$];
    logic [19:0] exp_q[$];
    int          r_total;
    logic [N-1:0] r_dv;
    logic [IDW-1:0] r_gid;
    bit          r_busy_ok;
    bit          r_tmo;

    timer_share_ctrl #(.N_REQ(N), .IDW(IDW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .delay          (delay),
        .done           (done),
        .grant_id       (grant_id),
        .busy           (busy),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .timer_irq      (timer_irq)
    );

    always #5 clk = ~clk;

    // Interval timer: load period on START, count to zero, flag timeout, irq one cycle later.
    logic [31:0] t_period;
    logic [31:0] t_count;
    logic        t_run;
    logic        t_to;
    logic        t_ito;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_period <= 32'd0; t_count <= 32'd0; t_run <= 1'b0;
            t_to <= 1'b0; t_ito <= 1'b0; timer_irq <= 1'b0;
        end else begin
            timer_irq <= t_to & t_ito;
            if (t_run) begin
                if (t_count == 32'd0) begin
                    t_to  <= 1'b1;
                    t_run <= 1'b0;
                end else begin
                    t_count <= t_count - 32'd1;
                end
            end
            if (avm_chipselect && !avm_write_n) begin
                case (avm_address)
                    3'd2: t_period[15:0]  <= avm_writedata;
                    3'd3: t_period[31:16] <= avm_writedata;
                    3'd1: begin
                        t_ito <= avm_writedata[0];
                        if (avm_writedata[2]) begin
                            t_run   <= 1'b1;
                            t_count <= t_period;
                        end
                    end
                    3'd0: t_to <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    // Expected bus writes for one service of delay d.
    task automatic mk_exp(input logic [31:0] d);
        exp_q.delete();
        if (d != 32'd0) begin
            exp_q.push_back({1'b0, 3'd2, d[15:0]});
            exp_q.push_back({1'b0, 3'd3, d[31:16]});
            exp_q.push_back({1'b0, 3'd1, 16'h0005});
            exp_q.push_back({1'b0, 3'd0, 16'h0000});
        end
    endtask

    // Called at a negedge in the IDLE cycle; observes one service up to its done cycle.
    task automatic run_svc(input int budget, input bit scramble, input int sid);
        int  cyc;
        bit  stop;
        cyc = 0; stop = 1'b0;
        r_busy_ok = 1'b1; r_tmo = 1'b0; r_dv = '0; r_gid = '0;
        bus_q.delete();
        while (!stop) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) r_gid = grant_id;
            if (!busy) r_busy_ok = 1'b0;
            if (avm_chipselect) bus_q.push_back({avm_write_n, avm_address, avm_writedata});
            if (scramble && cyc == 2) delay[32*sid +: 32] = $urandom;
            if (done != '0) begin
                r_dv = done;
                stop = 1'b1;
            end else if (cyc >= budget) begin
                r_tmo = 1'b1;
                stop = 1'b1;
            end
        end
        r_total = cyc + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_status done=%b busy=%b gid=%0d required 0000/0/0", done, busy, grant_id);
        end
        checks++;
        if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1) begin
            failures++;
            $display("FAIL reset_strobes cs=%b wn=%b required 0/1", avm_chipselect, avm_write_n);
        end
        checks++;
        if (avm_address !== 3'd0 || avm_writedata !== 16'h0000) begin
            failures++;
            $display("FAIL reset_bus addr=%0d data=%h required 0/0000", avm_address, avm_writedata);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int extra;
        delay[31:0] = 32'd100;
        req = 4'b0001;
        mk_exp(32'd100);
        run_svc(500, 1'b0, 0);
        req = 4'b0000;
        checks++;
        if (r_tmo || r_dv !== 4'b0001 || r_gid !== 2'd0) begin
            failures++;
            $display("FAIL single_done tmo=%0d done=%b gid=%0d required 0/0001/0", r_tmo, r_dv, r_gid);
        end
        checks++;
        if (r_total < 109 || r_total > 111) begin
            failures++;
            $display("FAIL single_latency cycles=%0d required 109..111", r_total);
        end
        checks++;
        if (!r_busy_ok) begin
            failures++;
            $display("FAIL single_busy busy dropped during service, required high");
        end
        checks++;
        if (bus_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL single_nwrites got=%0d required %0d", bus_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (bus_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL single_write%0d got=%h required %h", i, bus_q[i], exp_q[i]);
                end
            end
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (done != '0 || busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL single_once extra_done_or_busy=%0d required 0", extra);
        end
    endtask

    task automatic test_all_four();
        int extra;
        do_reset();
        for (int i = 0; i < N; i++) delay[32*i +: 32] = 32'd10;
        req = 4'b1111;
        for (int s = 0; s < N; s++) begin
            run_svc(200, 1'b0, 0);
            checks++;
            if (r_tmo || r_dv !== (4'b0001 << s)) begin
                failures++;
                $display("FAIL order_%0d tmo=%0d done=%b required %b", s, r_tmo, r_dv, 4'b0001 << s);
            end
            req[s] = 1'b0;
            if (s == N - 1) req[2] = 1'b1;
            @(negedge clk);
        end
        run_svc(200, 1'b0, 0);
        req = 4'b0000;
        checks++;
        if (r_tmo || r_dv !== 4'b0100) begin
            failures++;
            $display("FAIL rerequest_2 tmo=%0d done=%b required 0100", r_tmo, r_dv);
        end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done != '0) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL rerequest_alone extra_done=%0d required 0", extra);
        end
    endtask

    task automatic test_wide();
        delay[63:32] = 32'h0001_0000;
        req = 4'b0010;
        mk_exp(32'h0001_0000);
        run_svc(70000, 1'b0, 1);
        req = 4'b0000;
        checks++;
        if (r_tmo || r_dv !== 4'b0010) begin
            failures++;
            $display("FAIL wide_done tmo=%0d done=%b required 0010", r_tmo, r_dv);
        end
        checks++;
        if (r_total < 65545 || r_total > 65547) begin
            failures++;
            $display("FAIL wide_latency cycles=%0d required 65545..65547", r_total);
        end
        checks++;
        if (bus_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL wide_nwrites got=%0d required %0d", bus_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (bus_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL wide_write%0d got=%h required %h", i, bus_q[i], exp_q[i]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_zero();
        delay[95:64] = 32'd0;
        req = 4'b0100;
        run_svc(10, 1'b0, 2);
        req = 4'b0000;
        checks++;
        if (r_tmo || r_dv !== 4'b0100 || r_total != 2) begin
            failures++;
            $display("FAIL zero_done tmo=%0d done=%b cycles=%0d required 0/0100/2", r_tmo, r_dv, r_total);
        end
        checks++;
        if (bus_q.size() != 0 || !r_busy_ok) begin
            failures++;
            $display("FAIL zero_bus writes=%0d busy_ok=%0d required 0/1", bus_q.size(), r_busy_ok);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int seen;
        delay[31:0] = 32'd1000;
        req = 4'b0001;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done != '0) seen++;
        end
        reset_n = 1'b0;
        req = 4'b0000;
        #1;
        checks++;
        if (done !== 4'b0000 || busy !== 1'b0 || avm_chipselect !== 1'b0 || avm_write_n !== 1'b1 ||
            avm_address !== 3'd0 || avm_writedata !== 16'h0000 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL midreset_outputs done=%b busy=%b cs=%b wn=%b addr=%0d data=%h gid=%0d required reset values",
                     done, busy, avm_chipselect, avm_write_n, avm_address, avm_writedata, grant_id);
        end
        repeat (3) begin
            @(negedge clk);
            if (done != '0) seen++;
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (seen != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_nodone done_pulses=%0d busy=%b required 0/0", seen, busy);
        end
        delay[31:0] = 32'd20;
        req = 4'b0001;
        mk_exp(32'd20);
        run_svc(200, 1'b0, 0);
        req = 4'b0000;
        checks++;
        if (r_tmo || r_dv !== 4'b0001 || r_total < 29 || r_total > 31) begin
            failures++;
            $display("FAIL midreset_redo tmo=%0d done=%b cycles=%0d required 0/0001/29..31", r_tmo, r_dv, r_total);
        end
        checks++;
        if (bus_q != exp_q) begin
            failures++;
            $display("FAIL midreset_writes got=%p required %p", bus_q, exp_q);
        end
        @(negedge clk);
    endtask

    task automatic test_rr_hold();
        do_reset();
        for (int i = 0; i < N; i++) delay[32*i +: 32] = 32'd5;
        req = 4'b1001;
        run_svc(100, 1'b0, 0);
        checks++;
        if (r_tmo || r_dv !== 4'b0001) begin
            failures++;
            $display("FAIL hold_first done=%b required 0001", r_dv);
        end
        @(negedge clk);
        run_svc(100, 1'b0, 3);
        req[3] = 1'b0;
        checks++;
        if (r_tmo || r_dv !== 4'b1000) begin
            failures++;
            $display("FAIL hold_second done=%b required 1000", r_dv);
        end
        @(negedge clk);
        run_svc(100, 1'b0, 0);
        req = 4'b0000;
        checks++;
        if (r_tmo || r_dv !== 4'b0001) begin
            failures++;
            $display("FAIL hold_third done=%b required 0001", r_dv);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [N-1:0] pend;
        int mptr, eid, max_wait;
        int wait_cnt[N];
        logic [31:0] ed;
        bit scr;
        do_reset();
        mptr = N - 1;
        max_wait = 0;
        pend = '0;
        while (pend == '0) pend = N'($urandom_range(0, 15));
        for (int j = 0; j < N; j++) begin
            delay[32*j +: 32] = $urandom_range(0, 40);
            wait_cnt[j] = 0;
        end
        req = pend;
        for (int s = 0; s < 40; s++) begin
            eid = -1;
            for (int k = 1; k <= N && eid < 0; k++) begin
                if (pend[(mptr + k) % N]) eid = (mptr + k) % N;
            end
            ed = delay[32*eid +: 32];
            mk_exp(ed);
            scr = ($urandom_range(0, 1) == 1);
            run_svc(400, scr, eid);
            checks++;
            if (r_tmo || r_dv !== (4'b0001 << eid) || r_gid !== IDW'(eid)) begin
                failures++;
                $display("FAIL rand_grant svc=%0d tmo=%0d done=%b gid=%0d required done=%b gid=%0d",
                         s, r_tmo, r_dv, r_gid, 4'b0001 << eid, eid);
            end
            checks++;
            if (bus_q != exp_q || r_total != ((ed == 32'd0) ? 2 : int'(ed) + 9)) begin
                failures++;
                $display("FAIL rand_service svc=%0d writes=%p cycles=%0d required %p delay=%0d",
                         s, bus_q, r_total, exp_q, ed);
            end
            mptr = eid;
            for (int j = 0; j < N; j++) begin
                if (j != eid && pend[j]) begin
                    wait_cnt[j]++;
                    if (wait_cnt[j] > max_wait) max_wait = wait_cnt[j];
                end
            end
            pend[eid] = ($urandom_range(0, 3) == 0);
            if (pend[eid]) delay[32*eid +: 32] = $urandom_range(0, 40);
            wait_cnt[eid] = 0;
            for (int j = 0; j < N; j++) begin
                if (!pend[j] && $urandom_range(0, 2) == 0) begin
                    pend[j] = 1'b1;
                    delay[32*j +: 32] = $urandom_range(0, 40);
                    wait_cnt[j] = 0;
                end
            end
            if (pend == '0) begin
                eid = $urandom_range(0, N - 1);
                pend[eid] = 1'b1;
                delay[32*eid +: 32] = $urandom_range(0, 40);
            end
            req = pend;
            @(negedge clk);
        end
        req = '0;
        checks++;
        if (max_wait > N - 1) begin
            failures++;
            $display("FAIL rand_starvation max_wait=%0d required <=%0d", max_wait, N - 1);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req = '0;
        delay = '0;
        test_reset();
        test_single();
        test_all_four();
        test_wide();
        test_zero();
        test_reset_mid();
        test_rr_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
